// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory fetch bus with busywait handshake
`timescale 1ns/1ps

interface instr_fetch_unit_if;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READ;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;

  modport master (
    output IMEM_ADDR,
    output IMEM_READ,
    input  IMEM_READDATA,
    input  IMEM_BUSYWAIT
  );

  modport slave (
    input  IMEM_ADDR,
    input  IMEM_READ,
    output IMEM_READDATA,
    output IMEM_BUSYWAIT
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32 fetch stage: PC, busywait fetch, IF/ID register, stall hold and redirect
`timescale 1ns/1ps

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     RESET,
  instr_fetch_unit_if.master       imem,
  input  logic                     STALL,
  input  logic                     BRANCH_TAKEN,
  input  logic [31:0]              BRANCH_TARGET,
  output logic [31:0]              PC_OUT,
  output logic [31:0]              PC_PLUS4_OUT,
  output logic [31:0]              INSTRUCTION,
  output logic                     VALID
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DISCARD
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] buf_data;
  logic [31:0] pc_plus4;
  logic [31:0] branch_pc;
  logic        done;

  assign pc_plus4  = pc + 32'd4;
  assign branch_pc = BRANCH_TARGET & ~32'h3;

  // Read/address decode only from state, so memory never sees a path from STALL or BRANCH_TAKEN
  assign imem.IMEM_READ = (state == FETCH) || (state == DISCARD);
  assign imem.IMEM_ADDR = (state == DISCARD) ? req_addr : pc;
  assign done           = imem.IMEM_READ && !imem.IMEM_BUSYWAIT;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      req_addr     <= RESET_PC;
      buf_data     <= 32'h0;
      PC_OUT       <= 32'h0;
      PC_PLUS4_OUT <= 32'h0;
      INSTRUCTION  <= NOP;
      VALID        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end

        FETCH: begin
          req_addr <= pc;
          if (BRANCH_TAKEN) begin
            // An access still busy must be drained at its old address before refetching
            pc          <= branch_pc;
            INSTRUCTION <= NOP;
            VALID       <= 1'b0;
            state       <= imem.IMEM_BUSYWAIT ? DISCARD : FETCH;
          end else if (done && !STALL) begin
            PC_OUT       <= pc;
            PC_PLUS4_OUT <= pc_plus4;
            INSTRUCTION  <= imem.IMEM_READDATA;
            VALID        <= 1'b1;
            pc           <= pc_plus4;
          end else if (done) begin
            buf_data <= imem.IMEM_READDATA;
            state    <= HOLD;
          end else if (!STALL) begin
            INSTRUCTION <= NOP;
            VALID       <= 1'b0;
          end
        end

        HOLD: begin
          if (BRANCH_TAKEN) begin
            pc          <= branch_pc;
            INSTRUCTION <= NOP;
            VALID       <= 1'b0;
            state       <= FETCH;
          end else if (!STALL) begin
            PC_OUT       <= pc;
            PC_PLUS4_OUT <= pc_plus4;
            INSTRUCTION  <= buf_data;
            VALID        <= 1'b1;
            pc           <= pc_plus4;
            state        <= FETCH;
          end
        end

        DISCARD: begin
          if (BRANCH_TAKEN) begin
            pc <= branch_pc;
          end
          if (done) begin
            state <= FETCH;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized bench for instr_fetch_unit against an instruction-stream model
`timescale 1ns/1ps

module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'h0;
  logic [31:0] PC_OUT;
  logic [31:0] PC_PLUS4_OUT;
  logic [31:0] INSTRUCTION;
  logic        VALID;

  instr_fetch_unit_if imem_bus ();

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .imem          (imem_bus),
    .STALL         (STALL),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .PC_OUT        (PC_OUT),
    .PC_PLUS4_OUT  (PC_PLUS4_OUT),
    .INSTRUCTION   (INSTRUCTION),
    .VALID         (VALID)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // memory model state
  int fixed_lat = 0;
  int cnt = 0;
  int cur_lat = 0;

  // instruction-stream model: next program-order address and the expected IF/ID contents
  logic [31:0] exp_pc;
  logic [31:0] exp_out_pc;
  logic [31:0] exp_instr;
  logic        exp_valid;
  logic        delivered;
  int          run;
  int          gap;
  int          strict_gap = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc     = RST_PC;
    exp_out_pc = 32'h0;
    exp_instr  = NOP;
    exp_valid  = 1'b0;
    delivered  = 1'b0;
    run        = 0;
    gap        = 0;
    cnt        = 0;
  endtask

  task automatic step(input logic st, input logic br, input logic [31:0] tgt);
    logic        pre_read;
    logic        pre_busy;
    logic [31:0] pre_addr;
    STALL         = st;
    BRANCH_TAKEN  = br;
    BRANCH_TARGET = tgt;
    if (imem_bus.IMEM_READ) begin
      if (cnt == 0) cur_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      imem_bus.IMEM_BUSYWAIT = (cnt < cur_lat);
    end else begin
      imem_bus.IMEM_BUSYWAIT = 1'b0;
    end
    imem_bus.IMEM_READDATA = mem_word(imem_bus.IMEM_ADDR);
    pre_read = imem_bus.IMEM_READ;
    pre_busy = imem_bus.IMEM_BUSYWAIT;
    pre_addr = imem_bus.IMEM_ADDR;

    @(posedge CLK);
    #1;

    if (pre_read) cnt = pre_busy ? cnt + 1 : 0;
    if (pre_read && pre_busy) begin
      check_eq("addr_hold", imem_bus.IMEM_ADDR, pre_addr);
      check_eq("read_hold", {31'h0, imem_bus.IMEM_READ}, 32'h1);
    end
    if (imem_bus.IMEM_READ) check_eq("addr_align", {30'h0, imem_bus.IMEM_ADDR[1:0]}, 32'h0);

    gap++;
    delivered = 1'b0;
    if (br) begin
      exp_pc    = tgt & ~32'h3;
      exp_valid = 1'b0;
      exp_instr = NOP;
      check_eq("flush_valid", {31'h0, VALID}, 32'h0);
      check_eq("flush_instr", INSTRUCTION, NOP);
    end else if (st) begin
      check_eq("stall_valid", {31'h0, VALID}, {31'h0, exp_valid});
      check_eq("stall_instr", INSTRUCTION, exp_instr);
      if (exp_valid) check_eq("stall_pc", PC_OUT, exp_out_pc);
    end else if (VALID) begin
      check_eq("pc_out", PC_OUT, exp_pc);
      check_eq("pc_plus4", PC_PLUS4_OUT, exp_pc + 32'd4);
      check_eq("instr", INSTRUCTION, mem_word(exp_pc));
      exp_out_pc = exp_pc;
      exp_instr  = mem_word(exp_pc);
      exp_valid  = 1'b1;
      exp_pc     = exp_pc + 32'd4;
      delivered  = 1'b1;
      if (strict_gap > 0) check_eq("gap", gap, strict_gap);
      gap = 0;
    end else begin
      check_eq("bubble_instr", INSTRUCTION, NOP);
      exp_valid = 1'b0;
      exp_instr = NOP;
    end

    if (delivered) run = 0;
    else if (!st && !br) run++;
    check_eq("starve", {31'h0, run <= 10}, 32'h1);
  endtask

  task automatic wait_delivery(input string tag);
    for (int i = 0; i < 12 && !delivered; i++) step(1'b0, 1'b0, 32'h0);
    check_eq(tag, {31'h0, delivered}, 32'h1);
  endtask

  initial begin
    imem_bus.IMEM_BUSYWAIT = 1'b0;
    imem_bus.IMEM_READDATA = 32'h0;
    model_reset();

    #12;
    check_eq("rst_read", {31'h0, imem_bus.IMEM_READ}, 32'h0);
    check_eq("rst_addr", imem_bus.IMEM_ADDR, RST_PC);
    check_eq("rst_pc_out", PC_OUT, 32'h0);
    check_eq("rst_pc4_out", PC_PLUS4_OUT, 32'h0);
    check_eq("rst_instr", INSTRUCTION, NOP);
    check_eq("rst_valid", {31'h0, VALID}, 32'h0);
    RESET = 1'b1;

    // zero-wait latency and throughput
    fixed_lat = 0;
    step(1'b0, 1'b0, 32'h0);
    check_eq("lat_e1_valid", {31'h0, VALID}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("lat_e2_valid", {31'h0, VALID}, 32'h1);
    check_eq("lat_e2_pc", PC_OUT, RST_PC);
    strict_gap = 1;
    repeat (4) step(1'b0, 1'b0, 32'h0);
    strict_gap = 0;

    // three-wait memory: three bubbles between instructions
    fixed_lat = 3;
    delivered = 1'b0;
    wait_delivery("lat3_sync");
    strict_gap = 4;
    repeat (12) step(1'b0, 1'b0, 32'h0);
    strict_gap = 0;

    // stall coinciding with a completing fetch at 0x10
    fixed_lat = 0;
    step(1'b0, 1'b1, 32'h0000_000C);
    wait_delivery("stall_sync");
    step(1'b1, 1'b0, 32'h0);
    check_eq("hold_read", {31'h0, imem_bus.IMEM_READ}, 32'h0);
    repeat (3) step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("release_pc", PC_OUT, 32'h10);
    check_eq("release_next_addr", imem_bus.IMEM_ADDR, 32'h14);
    check_eq("release_next_read", {31'h0, imem_bus.IMEM_READ}, 32'h1);
    step(1'b0, 1'b0, 32'h0);

    // branch and stall together while holding a buffered word
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0300);
    check_eq("hold_br_addr", imem_bus.IMEM_ADDR, 32'h300);
    check_eq("hold_br_read", {31'h0, imem_bus.IMEM_READ}, 32'h1);
    step(1'b0, 1'b0, 32'h0);
    check_eq("hold_br_pc", PC_OUT, 32'h300);

    // redirect to misaligned target during an in-flight access at 0x40
    step(1'b0, 1'b1, 32'h0000_003C);
    wait_delivery("inflight_sync");
    fixed_lat = 3;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0203);
    check_eq("disc_addr", imem_bus.IMEM_ADDR, 32'h40);
    fixed_lat = 0;
    for (int i = 0; i < 6 && imem_bus.IMEM_ADDR == 32'h40; i++) step(1'b0, 1'b0, 32'h0);
    check_eq("disc_next_addr", imem_bus.IMEM_ADDR, 32'h200);
    step(1'b0, 1'b0, 32'h0);
    check_eq("disc_valid", {31'h0, VALID}, 32'h1);
    check_eq("disc_pc", PC_OUT, 32'h200);

    // PC wrap-around
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    wait_delivery("wrap_sync");
    check_eq("wrap_pc4", PC_PLUS4_OUT, 32'h0);
    check_eq("wrap_next_addr", imem_bus.IMEM_ADDR, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("wrap_pc_zero", PC_OUT, 32'h0);

    // asynchronous reset in the middle of a busy access
    fixed_lat = 3;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    #2 RESET = 1'b0;
    #1;
    check_eq("arst_read", {31'h0, imem_bus.IMEM_READ}, 32'h0);
    check_eq("arst_addr", imem_bus.IMEM_ADDR, RST_PC);
    check_eq("arst_valid", {31'h0, VALID}, 32'h0);
    check_eq("arst_instr", INSTRUCTION, NOP);
    check_eq("arst_pc_out", PC_OUT, 32'h0);
    check_eq("arst_pc4_out", PC_PLUS4_OUT, 32'h0);
    #2 RESET = 1'b1;
    model_reset();
    fixed_lat = 0;
    step(1'b0, 1'b0, 32'h0);
    check_eq("rerst_e1_valid", {31'h0, VALID}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("rerst_e2_valid", {31'h0, VALID}, 32'h1);

    // randomized stalls, redirects and memory latency
    fixed_lat = -1;
    for (int i = 0; i < 400; i++) begin
      logic        st;
      logic        br;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 11) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                                        : ($urandom & 32'h0000_0FFF);
      step(st, br, tgt);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
